// File: rtl/flappybird_led_pkg.sv
// Shared types and default sizes for the LED driver stage that sits behind the 14-bit LED PIO.
// Build option: define LEDS_GAMMA_EN to square the brightness setting before PWM.
package flappybird_led_pkg;

   localparam int LED_WIDTH    = 14;
   localparam int LED_PWM_BITS = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLASH_OFF = 2'd1,
      FLASH_ON  = 2'd2
   } led_flash_state_t;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM generator producing the global dimming enable for all LED lanes.
// Build option LEDS_GAMMA_EN: brightness is squared and registered before the duty compare.
module led_pwm_gen
   import flappybird_led_pkg::*;
#(
   parameter int PWM_BITS = LED_PWM_BITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                pwm_on
);

   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] pwm_cnt_d;
   logic [PWM_BITS-1:0] brightness_eff;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

`ifdef LEDS_GAMMA_EN
   logic [2*PWM_BITS-1:0] bright_sq;
   logic [PWM_BITS-1:0]   bright_eff_d;
   logic [PWM_BITS-1:0]   bright_eff_q;

   always_comb begin
      bright_sq    = {{PWM_BITS{1'b0}}, brightness} * {{PWM_BITS{1'b0}}, brightness};
      bright_eff_d = bright_sq[2*PWM_BITS-1:PWM_BITS];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bright_eff_q <= '0;
      end else begin
         bright_eff_q <= bright_eff_d;
      end
   end

   assign brightness_eff = bright_eff_q;
`else
   assign brightness_eff = brightness;
`endif

   // Full-scale setting must be truly 100%, which the strict < compare cannot reach.
   always_comb begin
      pwm_on = (&brightness) | (pwm_cnt_q < brightness_eff);
   end

endmodule

// File: rtl/flappybird_led_driver.sv
// LED output stage: registers the PIO pattern, applies PWM dimming and plays a blink on pattern change.
// Build option LEDS_GAMMA_EN selects the squared brightness response inside led_pwm_gen.
module flappybird_led_driver
   import flappybird_led_pkg::*;
#(
   parameter int WIDTH       = LED_WIDTH,
   parameter int PWM_BITS    = LED_PWM_BITS,
   parameter int FLASH_TICKS = 2500000,
   parameter int FLASH_COUNT = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    pattern_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                flash_enable,
   output logic [WIDTH-1:0]    led_out,
   output logic                busy
);

   localparam int TICK_W = $clog2(FLASH_TICKS + 1);
   localparam int FC_W   = $clog2(FLASH_COUNT + 1);
   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(FLASH_TICKS - 1);
   localparam logic [FC_W-1:0]   FC_LAST     = FC_W'(FLASH_COUNT - 1);

   led_flash_state_t  state_q, state_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [FC_W-1:0]   flash_cnt_q, flash_cnt_d;
   logic [WIDTH-1:0]  pattern_q, pattern_d;
   logic [WIDTH-1:0]  led_q, led_d;
   logic              busy_q, busy_d;
   logic              chg;
   logic              pwm_on;

   led_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk        (clk),
      .reset_n    (reset_n),
      .brightness (brightness),
      .pwm_on     (pwm_on)
   );

   // Disable beats a fresh change, and a fresh change beats half-period expiry.
   always_comb begin
      pattern_d   = pattern_in;
      chg         = (pattern_in != pattern_q);
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      flash_cnt_d = flash_cnt_q;

      case (state_q)
         IDLE: begin
            if (chg && flash_enable) begin
               state_d     = FLASH_OFF;
               tick_cnt_d  = TICK_RELOAD;
               flash_cnt_d = '0;
            end
         end
         default: begin
            if (!flash_enable) begin
               state_d     = IDLE;
               tick_cnt_d  = '0;
               flash_cnt_d = '0;
            end else if (chg) begin
               state_d     = FLASH_OFF;
               tick_cnt_d  = TICK_RELOAD;
               flash_cnt_d = '0;
            end else if (tick_cnt_q != '0) begin
               tick_cnt_d = tick_cnt_q - TICK_W'(1);
            end else if (state_q == FLASH_OFF) begin
               state_d    = FLASH_ON;
               tick_cnt_d = TICK_RELOAD;
            end else if (flash_cnt_q == FC_LAST) begin
               state_d = IDLE;
            end else begin
               state_d     = FLASH_OFF;
               tick_cnt_d  = TICK_RELOAD;
               flash_cnt_d = flash_cnt_q + FC_W'(1);
            end
         end
      endcase

      busy_d = (state_d != IDLE);
      led_d  = pattern_q & {WIDTH{pwm_on && (state_q != FLASH_OFF)}};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         flash_cnt_q <= '0;
         pattern_q   <= '0;
         led_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         flash_cnt_q <= flash_cnt_d;
         pattern_q   <= pattern_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
      end
   end

   assign led_out = led_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_flappybird_led_driver.sv
// Directed bench for flappybird_led_driver: PWM duty table plus hand-built flash, restart and abort sequences.
// Expected duty values follow LEDS_GAMMA_EN when the bench is built with it.
module tb_flappybird_led_driver;

   logic        clk;
   logic        reset_n;
   logic [13:0] pattern_in;
   logic [3:0]  brightness;
   logic        flash_enable;
   logic [13:0] led_out;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [13:0] pattern;
      logic [3:0]  bright;
      int          exp_on;
   } pwm_vec_t;

   pwm_vec_t vecs[6];

   flappybird_led_driver #(
      .WIDTH       (14),
      .PWM_BITS    (4),
      .FLASH_TICKS (4),
      .FLASH_COUNT (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pattern_in   (pattern_in),
      .brightness   (brightness),
      .flash_enable (flash_enable),
      .led_out      (led_out),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [13:0] p, input logic [3:0] b, input logic fe);
      pattern_in   = p;
      brightness   = b;
      flash_enable = fe;
   endtask

   task automatic checkOutput(input string name, input logic [13:0] exp_led, input logic exp_busy);
      checks++;
      if (led_out !== exp_led || busy !== exp_busy) begin
         errors++;
         $display("[TB] FAIL %s: got led_out=%h busy=%b, want led_out=%h busy=%b",
                  name, led_out, busy, exp_led, exp_busy);
      end
   endtask

   task automatic checkCount(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Park the DUT idle on an all-zero pattern so the next nonzero pattern is a clean change.
   task automatic settleZero();
      applyStimulus(14'h0000, 4'hF, 1'b0);
      repeat (3) tick();
   endtask

   initial begin
      int on_cnt;
      int bad_cnt;
      int busy_cnt;

      vecs[0] = '{"duty_b4",     14'h3FFF, 4'h4, 4};
      vecs[1] = '{"duty_b0",     14'h3FFF, 4'h0, 0};
      vecs[2] = '{"duty_bF",     14'h3FFF, 4'hF, 16};
      vecs[3] = '{"duty_b8",     14'h2A5A, 4'h8, 8};
      vecs[4] = '{"duty_b1",     14'h1555, 4'h1, 1};
      vecs[5] = '{"duty_bE",     14'h3FFF, 4'hE, 14};
`ifdef LEDS_GAMMA_EN
      vecs[0].exp_on = 1;
      vecs[3].exp_on = 4;
      vecs[4].exp_on = 0;
      vecs[5].exp_on = 12;
`endif

      // Reset, then the 2-cycle pattern latency with full brightness
      reset_n = 1'b0;
      applyStimulus(14'h0000, 4'hF, 1'b0);
      tick();
      checkOutput("reset_cycle1", 14'h0000, 1'b0);
      tick();
      checkOutput("reset_cycle2", 14'h0000, 1'b0);
      reset_n = 1'b1;
      applyStimulus(14'h2A5A, 4'hF, 1'b0);
      tick();
      checkOutput("latency_1cyc", 14'h0000, 1'b0);
      tick();
      checkOutput("latency_2cyc", 14'h2A5A, 1'b0);
      tick();
      checkOutput("steady", 14'h2A5A, 1'b0);

      // PWM duty table: count lit cycles over one full 16-cycle period
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].pattern, vecs[v].bright, 1'b0);
         repeat (3) tick();
         on_cnt  = 0;
         bad_cnt = 0;
         for (int c = 0; c < 16; c++) begin
            tick();
            if (led_out === vecs[v].pattern) on_cnt++;
            else if (led_out !== 14'h0000 || busy !== 1'b0) bad_cnt++;
         end
         checkCount(vecs[v].name, on_cnt, vecs[v].exp_on);
         checkCount({vecs[v].name, "_shape"}, bad_cnt, 0);
      end

      // Full flash sequence: 4 off, 4 on, 4 off, 4 on, then idle
      settleZero();
      applyStimulus(14'h0001, 4'hF, 1'b1);
      tick();
      checkOutput("flash_start", 14'h0000, 1'b1);
      for (int i = 1; i <= 16; i++) begin
         tick();
         checkOutput($sformatf("flash_step%0d", i),
                     (((i - 1) / 4) % 2 == 1) ? 14'h0001 : 14'h0000,
                     (i <= 15) ? 1'b1 : 1'b0);
      end
      tick();
      checkOutput("flash_done", 14'h0001, 1'b0);

      // Pattern change during the first on phase restarts the whole sequence
      settleZero();
      applyStimulus(14'h0001, 4'hF, 1'b1);
      repeat (5) tick();
      applyStimulus(14'h0003, 4'hF, 1'b1);
      tick();
      checkOutput("restart_edge", 14'h0001, 1'b1);
      tick();
      checkOutput("restart_off", 14'h0000, 1'b1);
      busy_cnt = 2;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (busy !== 1'b1) break;
         busy_cnt++;
      end
      checkCount("restart_busy_len", busy_cnt, 16);
      checkOutput("restart_done", 14'h0003, 1'b0);

      // Dropping flash_enable mid FLASH_OFF aborts at the next edge
      settleZero();
      applyStimulus(14'h0001, 4'hF, 1'b1);
      tick();
      tick();
      checkOutput("abort_pre", 14'h0000, 1'b1);
      applyStimulus(14'h0001, 4'hF, 1'b0);
      tick();
      checkOutput("abort_idle", 14'h0000, 1'b0);
      tick();
      checkOutput("abort_led", 14'h0001, 1'b0);

      // Reset in the middle of a sequence, then a nonzero pattern counts as a change
      settleZero();
      applyStimulus(14'h0001, 4'hF, 1'b1);
      repeat (6) tick();
      reset_n = 1'b0;
      applyStimulus(14'h0000, 4'hF, 1'b1);
      tick();
      checkOutput("midreset", 14'h0000, 1'b0);
      reset_n = 1'b1;
      tick();
      checkOutput("postreset_idle", 14'h0000, 1'b0);
      applyStimulus(14'h0005, 4'hF, 1'b1);
      tick();
      checkOutput("postreset_chg", 14'h0000, 1'b1);
      applyStimulus(14'h0005, 4'hF, 1'b0);
      tick();
      checkOutput("postreset_abort", 14'h0000, 1'b0);
      tick();
      checkOutput("postreset_led", 14'h0005, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
